// File: rtl/seq_flash_pkg.sv
// Shared types and helpers for the sequence flasher.
// Holds the FSM state encoding and the colour decoder.
package seq_flash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int MAX_COLOURS = 16;

  // Out-of-range colour indices decode to a dark lamp.
  function automatic logic [MAX_COLOURS-1:0] onehot_decode(
    input logic [3:0]  idx,
    input int unsigned ncol
  );
    logic [MAX_COLOURS-1:0] oh;
    oh = '0;
    if (32'(idx) < ncol) begin
      oh[idx] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter that paces the lit and blank phases.
// Load wins over decrement; the count holds at zero.
module flash_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_flash_ctrl.sv
// Plays a stored colour sequence on one-hot lamps, with a
// blank gap after each step and optional player echo.
module seq_flash_ctrl
  import seq_flash_pkg::*;
#(
  parameter int NUM_COLOURS = 4,
  parameter int MAX_STEPS   = 33,
  parameter int ON_TICKS    = 8,
  parameter int OFF_TICKS   = 4,
  localparam int CW = $clog2(NUM_COLOURS),
  localparam int SW = $clog2(MAX_STEPS + 1)
) (
  input  logic                    flash_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SW-1:0]           seq_len,
  input  logic [MAX_STEPS*CW-1:0] segment,
  input  logic                    echo_en,
  input  logic [NUM_COLOURS-1:0]  player_input,
  output logic [NUM_COLOURS-1:0]  disp_o,
  output logic                    busy,
  output logic                    done,
  output logic [SW-1:0]           step_idx
);

  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] ON_LD  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_TICKS - 1);
  localparam logic [SW-1:0] LEN_MX = SW'(MAX_STEPS);
  localparam logic [SW-1:0] STP_MX = SW'(MAX_STEPS - 1);

  state_e state_q;
  state_e state_d;

  logic [SW-1:0] step_q;
  logic [SW-1:0] step_d;
  logic [SW-1:0] len_q;
  logic [SW-1:0] len_d;

  logic [NUM_COLOURS-1:0] disp_q;
  logic [NUM_COLOURS-1:0] disp_d;
  logic                   busy_q;
  logic                   busy_d;
  logic                   done_q;
  logic                   done_d;
  logic [SW-1:0]          stepo_q;
  logic [SW-1:0]          stepo_d;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_dec;
  logic          t_zero;

  logic [SW-1:0]          len_clamp;
  logic [SW-1:0]          step_inc;
  logic                   last_step;
  logic [CW-1:0]          colour;
  logic [NUM_COLOURS-1:0] lamp;

  flash_timer #(
    .W(TW)
  ) u_timer (
    .clk_i      (flash_clk),
    .rst_ni     (reset_n),
    .load_i     (t_load),
    .load_val_i (t_val),
    .dec_i      (t_dec),
    .zero_o     (t_zero)
  );

  assign len_clamp = (seq_len > LEN_MX) ? LEN_MX : seq_len;
  assign step_inc  = (step_q == STP_MX) ? step_q : step_q + SW'(1);
  assign last_step = (step_q == len_q - SW'(1));

  always_ff @(posedge flash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
    end
  end

  // Abort overrides everything, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    t_load  = 1'b0;
    t_val   = ON_LD;
    t_dec   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      step_d  = '0;
      t_load  = 1'b1;
      t_val   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = len_clamp;
            step_d  = '0;
            t_load  = 1'b1;
            t_val   = ON_LD;
            state_d = (len_clamp == '0) ? FIN : ON;
          end
        end
        ON: begin
          if (t_zero) begin
            state_d = GAP;
            t_load  = 1'b1;
            t_val   = OFF_LD;
          end else begin
            t_dec = 1'b1;
          end
        end
        GAP: begin
          if (t_zero) begin
            if (last_step) begin
              state_d = FIN;
            end else begin
              state_d = ON;
              step_d  = step_inc;
              t_load  = 1'b1;
              t_val   = ON_LD;
            end
          end else begin
            t_dec = 1'b1;
          end
        end
        FIN: begin
          state_d = IDLE;
          step_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign colour = segment[int'(step_q) * CW +: CW];

  always_comb begin
    lamp    = NUM_COLOURS'(onehot_decode(4'(colour), NUM_COLOURS));
    disp_d  = echo_en ? player_input : '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    stepo_d = '0;
    if (!abort) begin
      stepo_d = step_q;
      busy_d  = (state_q == ON) || (state_q == GAP);
      done_d  = (state_q == FIN);
      if (state_q == ON) begin
        disp_d = disp_d | lamp;
      end
    end
  end

  always_ff @(posedge flash_clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stepo_q <= '0;
    end else begin
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stepo_q <= stepo_d;
    end
  end

  assign disp_o   = disp_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = stepo_q;

endmodule

// File: tb/tb_seq_flash_ctrl.sv
// Directed bench for seq_flash_ctrl: playback, clamp,
// abort, echo, async reset and out-of-range colours.
module tb_seq_flash_ctrl;

  logic flash_clk = 1'b0;
  always #5 flash_clk = ~flash_clk;

  logic        reset_n;
  logic        start;
  logic        abort;
  logic        echo_en;
  logic [5:0]  seq_len;
  logic [65:0] seg0;
  logic [65:0] seg1;
  logic [3:0]  pin0;
  logic [2:0]  pin1;
  logic        echo1;
  logic [3:0]  disp0;
  logic [2:0]  disp1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [5:0]  step0, step1;

  int checks = 0;
  int errors = 0;

  seq_flash_ctrl u_dut0 (
    .flash_clk    (flash_clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .seq_len      (seq_len),
    .segment      (seg0),
    .echo_en      (echo_en),
    .player_input (pin0),
    .disp_o       (disp0),
    .busy         (busy0),
    .done         (done0),
    .step_idx     (step0)
  );

  seq_flash_ctrl #(
    .NUM_COLOURS (3)
  ) u_dut1 (
    .flash_clk    (flash_clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .seq_len      (seq_len),
    .segment      (seg1),
    .echo_en      (echo1),
    .player_input (pin1),
    .disp_o       (disp1),
    .busy         (busy1),
    .done         (done1),
    .step_idx     (step1)
  );

  typedef struct {
    int         n;
    logic [3:0] disp;
    logic       busy;
    logic       done;
    logic [5:0] step;
  } phase_t;

  phase_t ph[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge flash_clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] len);
    seq_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic run_phases(input int sel, input int nph);
    for (int p = 0; p < nph; p++) begin
      for (int i = 0; i < ph[p].n; i++) begin
        tick();
        if (sel == 0) begin
          chk($sformatf("ph%0d.%0d disp", p, i), 32'(disp0), 32'(ph[p].disp));
          chk($sformatf("ph%0d.%0d busy", p, i), 32'(busy0), 32'(ph[p].busy));
          chk($sformatf("ph%0d.%0d done", p, i), 32'(done0), 32'(ph[p].done));
          chk($sformatf("ph%0d.%0d step", p, i), 32'(step0), 32'(ph[p].step));
        end else begin
          chk($sformatf("n3 ph%0d.%0d disp", p, i), 32'(disp1), 32'(ph[p].disp));
          chk($sformatf("n3 ph%0d.%0d busy", p, i), 32'(busy1), 32'(ph[p].busy));
          chk($sformatf("n3 ph%0d.%0d done", p, i), 32'(done1), 32'(ph[p].done));
          chk($sformatf("n3 ph%0d.%0d step", p, i), 32'(step1), 32'(ph[p].step));
        end
      end
    end
  endtask

  initial begin
    int busyc, onsets, maxs, dones, fin;
    logic [3:0] prev;

    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    echo_en = 1'b0;
    echo1   = 1'b0;
    seq_len = '0;
    seg0    = '0;
    seg1    = '0;
    pin0    = '0;
    pin1    = '0;
    repeat (2) tick();

    chk("rst disp0", 32'(disp0), 0);
    chk("rst busy0", 32'(busy0), 0);
    chk("rst done0", 32'(done0), 0);
    chk("rst step0", 32'(step0), 0);
    chk("rst disp1", 32'(disp1), 0);
    chk("rst busy1", 32'(busy1), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // basic playback of colours 0,2,3
    seg0[1:0] = 2'd0;
    seg0[3:2] = 2'd2;
    seg0[5:4] = 2'd3;
    ph[0] = '{8, 4'b0001, 1'b1, 1'b0, 6'd0};
    ph[1] = '{4, 4'b0000, 1'b1, 1'b0, 6'd0};
    ph[2] = '{8, 4'b0100, 1'b1, 1'b0, 6'd1};
    ph[3] = '{4, 4'b0000, 1'b1, 1'b0, 6'd1};
    ph[4] = '{8, 4'b1000, 1'b1, 1'b0, 6'd2};
    ph[5] = '{4, 4'b0000, 1'b1, 1'b0, 6'd2};
    ph[6] = '{1, 4'b0000, 1'b0, 1'b1, 6'd2};
    ph[7] = '{1, 4'b0000, 1'b0, 1'b0, 6'd0};
    do_start(6'd3);
    chk("t1 k0 disp", 32'(disp0), 0);
    chk("t1 k0 busy", 32'(busy0), 0);
    run_phases(0, 8);

    // zero length
    do_start(6'd0);
    chk("t2 k0 done", 32'(done0), 0);
    chk("t2 k0 busy", 32'(busy0), 0);
    tick();
    chk("t2 k1 done", 32'(done0), 1);
    chk("t2 k1 busy", 32'(busy0), 0);
    chk("t2 k1 disp", 32'(disp0), 0);
    tick();
    chk("t2 k2 done", 32'(done0), 0);
    chk("t2 k2 busy", 32'(busy0), 0);

    // clamp to MAX_STEPS and step index saturation
    for (int i = 0; i < 33; i++) seg0[i*2 +: 2] = 2'(i % 4);
    busyc  = 0;
    onsets = 0;
    maxs   = 0;
    dones  = 0;
    fin    = 0;
    prev   = '0;
    do_start(6'd40);
    for (int c = 0; c < 450 && fin == 0; c++) begin
      tick();
      if (busy0) busyc++;
      if (disp0 != 0 && prev == 0) onsets++;
      prev = disp0;
      if (int'(step0) > maxs) maxs = int'(step0);
      if (done0) begin
        dones++;
        fin = 1;
      end
    end
    repeat (10) begin
      tick();
      if (done0) dones++;
    end
    chk("t3 done seen", 32'(fin), 1);
    chk("t3 busy cycles", 32'(busyc), 396);
    chk("t3 steps lit", 32'(onsets), 33);
    chk("t3 step peak", 32'(maxs), 32);
    chk("t3 done count", 32'(dones), 1);

    // abort in step 1 ON
    seg0      = '0;
    seg0[3:2] = 2'd2;
    seg0[5:4] = 2'd3;
    do_start(6'd3);
    repeat (15) tick();
    chk("t4 pre disp", 32'(disp0), 32'h4);
    chk("t4 pre step", 32'(step0), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4 disp", 32'(disp0), 0);
    chk("t4 busy", 32'(busy0), 0);
    chk("t4 step", 32'(step0), 0);
    chk("t4 done", 32'(done0), 0);
    dones = 0;
    repeat (40) begin
      tick();
      if (done0 || busy0) dones++;
    end
    chk("t4 quiet after abort", 32'(dones), 0);
    do_start(6'd3);
    tick();
    chk("t4 replay disp", 32'(disp0), 32'h1);
    chk("t4 replay step", 32'(step0), 0);
    repeat (40) tick();

    // echo
    echo_en = 1'b1;
    pin0    = 4'b0010;
    do_start(6'd3);
    chk("t5 k0 echo", 32'(disp0), 32'h2);
    repeat (4) tick();
    chk("t5 on echo", 32'(disp0), 32'h3);
    repeat (6) tick();
    chk("t5 gap echo", 32'(disp0), 32'h2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5 abort echo", 32'(disp0), 32'h2);
    tick();
    chk("t5 idle echo", 32'(disp0), 32'h2);
    echo_en = 1'b0;
    do_start(6'd3);
    repeat (2) tick();
    chk("t5 no echo", 32'(disp0), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // async reset in step 1 gap
    do_start(6'd3);
    repeat (22) tick();
    chk("t6 pre busy", 32'(busy0), 1);
    chk("t6 pre step", 32'(step0), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6 rst busy0", 32'(busy0), 0);
    chk("t6 rst step0", 32'(step0), 0);
    chk("t6 rst disp0", 32'(disp0), 0);
    chk("t6 rst busy1", 32'(busy1), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      tick();
      if (done0 || busy0) dones++;
    end
    chk("t6 quiet after rst", 32'(dones), 0);

    // three colours, step 1 uses index 3
    seg1[1:0] = 2'd0;
    seg1[3:2] = 2'd3;
    seg1[5:4] = 2'd2;
    ph[0] = '{8, 4'b0001, 1'b1, 1'b0, 6'd0};
    ph[1] = '{4, 4'b0000, 1'b1, 1'b0, 6'd0};
    ph[2] = '{8, 4'b0000, 1'b1, 1'b0, 6'd1};
    ph[3] = '{4, 4'b0000, 1'b1, 1'b0, 6'd1};
    ph[4] = '{8, 4'b0100, 1'b1, 1'b0, 6'd2};
    ph[5] = '{4, 4'b0000, 1'b1, 1'b0, 6'd2};
    ph[6] = '{1, 4'b0000, 1'b0, 1'b1, 6'd2};
    ph[7] = '{1, 4'b0000, 1'b0, 1'b0, 6'd0};
    do_start(6'd3);
    chk("t7 k0 busy", 32'(busy1), 0);
    run_phases(1, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_flash_ctrl.md
Name: seq_flash_ctrl

Overview:
Parametrised successor to the single-step colour flasher. On `start`, it plays back a stored colour sequence of programmable length on one-hot lamp outputs. Each step is lit for a fixed on-time and followed by a blank gap. Player input is echoed onto the lamps when enabled. It sits between the game FSM (start/abort/done handshake) and the lamp drivers.

Parameters:
NUM_COLOURS, 4, number of lamps/colours (2..16)
MAX_STEPS, 33, depth of the sequence memory
ON_TICKS, 8, flash_clk cycles each step is lit (>=1)
OFF_TICKS, 4, flash_clk cycles of blank gap after each step (>=1)
(derived) CW = $clog2(NUM_COLOURS), SW = $clog2(MAX_STEPS+1)

Ports:
flash_clk  input  1  sole clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin playback; sampled only in IDLE
abort  input  1  stop playback immediately
seq_len  input  SW  number of steps to play
segment  input  MAX_STEPS*CW  colour index per step, step i at bits [i*CW +: CW]
echo_en  input  1  OR player_input onto lamps
player_input  input  NUM_COLOURS  one-hot player selection
disp_o  output  NUM_COLOURS  registered lamp drive
busy  output  1  high while in ON or GAP
done  output  1  one-cycle pulse when playback completes normally
step_idx  output  SW  index of the step currently playing

Behaviour:
- Reset (reset_n low, async): state=IDLE; disp_o=0, busy=0, done=0, step_idx=0, tick counter=0.
- States: IDLE, ON, GAP, FIN.
- IDLE, start=1, abort=0:
  - Latch len = min(seq_len, MAX_STEPS).
  - len==0 -> FIN.
  - Otherwise -> ON with step_idx=0, cnt=ON_TICKS-1.
- ON:
  - Lamp = decode(segment[step_idx]).
  - cnt==0 -> GAP with cnt=OFF_TICKS-1; else cnt--.
- GAP:
  - Lamp blank.
  - cnt==0 and step_idx==len-1 -> FIN.
  - cnt==0 otherwise -> ON with step_idx++ and cnt=ON_TICKS-1.
  - Else cnt--.
- FIN: done=1 for exactly one cycle, then IDLE; busy=0 in FIN.
- Latency: start sampled at edge t -> disp_o shows step 0 from edge t+1 for ON_TICKS cycles. Total playback = len*(ON_TICKS+OFF_TICKS) cycles, then a 1-cycle done.
- decode: one-hot of the colour index. Index >= NUM_COLOURS -> all-zero lamp for that step; timing is unchanged.
- disp_o (registered) = flash_lamp | (echo_en ? player_input : 0). Echo is active in every state, including IDLE.
- abort:
  - Highest priority: from ON/GAP/FIN -> IDLE next edge.
  - disp_o flash component cleared; no done pulse; step_idx=0.
  - abort and start together in IDLE -> stay IDLE.
- start while busy: ignored.
- seq_len and segment are sampled live each step; they must be held stable during playback by the FSM. Only len is latched.
- step_idx saturates at MAX_STEPS-1; it never wraps.
- Reset mid-playback: immediate return to reset values; no done.

Decomposition:
- Package seq_flash_pkg: state enum typedef (IDLE, ON, GAP, FIN); function onehot_decode(idx) parametrised by NUM_COLOURS.
- One sub-module: flash_timer (loadable down-counter with zero flag, width $clog2(max(ON_TICKS,OFF_TICKS))).
- FSM, step index and output register stay in the top level.

Test Plan:
1. Basic playback: NUM_COLOURS=4, ON=8, OFF=4, seq_len=3, segment={0,2,3}, start pulse.
   - disp_o = 0001 (8 cycles), 0000 (4), 0100 (8), 0000 (4), 1000 (8), 0000 (4).
   - done pulses at cycle 37 after start; busy high cycles 1-36.
2. Zero length: seq_len=0, start -> done pulses on the second edge after start; busy never high; disp_o stays 0.
3. Clamp and saturation: seq_len=40 with MAX_STEPS=33 -> exactly 33 steps played, step_idx peaks at 32, single done.
4. Abort: abort asserted during step 1's ON phase -> next edge disp_o=0000 (echo off), busy=0, step_idx=0, no done. A later start replays from step 0.
5. Echo: echo_en=1, player_input=0010 during step 0 (colour 0) -> disp_o=0011. In the gap -> 0010. In IDLE -> 0010. With echo_en=0 -> 0001.
6. Reset and out-of-range colours: reset_n low mid-GAP -> all outputs 0 asynchronously. With NUM_COLOURS=3, segment index 3 -> blank step of 8 cycles, sequence continues.
